ioctl_streamer: RTL and testbench



---
 rtl/ioctl_pkg.sv | 27 ++
 rtl/ioctl_streamer.sv | 223 ++++++++++++++++++++++
 tb/tb_ioctl_streamer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_pkg.sv
// ============================================================================
//  Module      : ioctl_pkg
//  Description : Shared types and constants for the HPS ioctl transfer engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ioctl_pkg;

    localparam int c_IOCTL_AW = 25;

    localparam logic [7:0] HS_CONFIGINDEX = 8'd3;
    localparam logic [7:0] HS_DUMPINDEX   = 8'd4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DL_FETCH   = 3'd1,
        S_DL_WRITE   = 3'd2,
        S_DL_GAP     = 3'd3,
        S_UL_HOLD    = 3'd4,
        S_UL_CAPTURE = 3'd5,
        S_TAIL       = 3'd6
    } ioctl_state_t;

endpackage

`default_nettype wire

// File: rtl/ioctl_streamer.sv
// ============================================================================
//  Module      : ioctl_streamer
//  Description : Core-side ioctl initiator; streams a local byte buffer out as
//                a download or captures an upload back into the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ioctl_streamer
    import ioctl_pkg::*;
#(
    parameter int BUF_AW  = 8,
    parameter int WR_GAP  = 3,
    parameter int UL_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_upload,
    input  logic [7:0]            cmd_index,
    input  logic [BUF_AW:0]       cmd_length,
    output logic                  busy,
    output logic                  done,
    output logic [BUF_AW-1:0]     buf_addr,
    input  logic [7:0]            buf_rdata,
    output logic [7:0]            buf_wdata,
    output logic                  buf_we,
    output logic                  ioctl_download,
    output logic                  ioctl_upload,
    output logic                  ioctl_wr,
    output logic [c_IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]            ioctl_dout,
    input  logic [7:0]            ioctl_din,
    output logic [7:0]            ioctl_index
);

    localparam logic [BUF_AW:0] c_ONE       = (BUF_AW+1)'(1);
    localparam logic [7:0]      c_GAP_LAST  = 8'((WR_GAP > 0) ? (WR_GAP - 1) : 0);
    localparam logic [7:0]      c_HOLD_LAST = 8'(UL_HOLD - 1);

    ioctl_state_t      state_q, state_d;
    logic [BUF_AW:0]   i_q, i_d;
    logic [BUF_AW:0]   len_q, len_d;
    logic [7:0]        wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BUF_AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_wdata_q, buf_wdata_d;
    logic              buf_we_q, buf_we_d;
    logic              dl_q, dl_d;
    logic              ul_q, ul_d;
    logic              wr_q, wr_d;
    logic [BUF_AW-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;

    logic [BUF_AW:0]   w_i_next;
    logic              w_last;

    assign w_i_next = i_q + c_ONE;
    assign w_last   = (w_i_next == len_q);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        len_d       = len_q;
        wait_d      = wait_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_we_d    = 1'b0;
        dl_d        = dl_q;
        ul_d        = ul_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        dout_d      = dout_q;
        index_d     = index_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    index_d = cmd_index;
                    len_d   = cmd_length;
                    i_d     = '0;
                    wait_d  = '0;
                    busy_d  = 1'b1;
                    if (cmd_length == '0) begin
                        state_d = S_TAIL;
                        dl_d    = ~cmd_upload;
                        ul_d    = cmd_upload;
                    end else if (cmd_upload) begin
                        state_d = S_UL_HOLD;
                        ul_d    = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d    = S_DL_FETCH;
                        dl_d       = 1'b1;
                        buf_addr_d = '0;
                    end
                end
            end

            // buf_addr was registered on entry; RAM data lands during DL_WRITE.
            S_DL_FETCH: state_d = S_DL_WRITE;

            S_DL_WRITE: begin
                dout_d = buf_rdata;
                addr_d = i_q[BUF_AW-1:0];
                wr_d   = 1'b1;
                wait_d = '0;
                if (WR_GAP != 0) begin
                    state_d = S_DL_GAP;
                end else if (w_last) begin
                    state_d = S_TAIL;
                end else begin
                    i_d        = w_i_next;
                    buf_addr_d = w_i_next[BUF_AW-1:0];
                    state_d    = S_DL_FETCH;
                end
            end

            S_DL_GAP: begin
                if (wait_q == c_GAP_LAST) begin
                    if (w_last) begin
                        state_d = S_TAIL;
                    end else begin
                        i_d        = w_i_next;
                        buf_addr_d = w_i_next[BUF_AW-1:0];
                        state_d    = S_DL_FETCH;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_UL_HOLD: begin
                if (wait_q == c_HOLD_LAST) begin
                    state_d = S_UL_CAPTURE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            // The last byte keeps its address so ioctl_addr holds after the transfer.
            S_UL_CAPTURE: begin
                buf_wdata_d = ioctl_din;
                buf_addr_d  = i_q[BUF_AW-1:0];
                buf_we_d    = 1'b1;
                wr_d        = 1'b1;
                wait_d      = '0;
                if (w_last) begin
                    state_d = S_TAIL;
                end else begin
                    i_d     = w_i_next;
                    addr_d  = w_i_next[BUF_AW-1:0];
                    state_d = S_UL_HOLD;
                end
            end

            S_TAIL: begin
                dl_d    = 1'b0;
                ul_d    = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            len_q       <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_we_q    <= 1'b0;
            dl_q        <= 1'b0;
            ul_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            len_q       <= len_d;
            wait_q      <= wait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_we_q    <= buf_we_d;
            dl_q        <= dl_d;
            ul_q        <= ul_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            index_q     <= index_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign buf_addr       = buf_addr_q;
    assign buf_wdata      = buf_wdata_q;
    assign buf_we         = buf_we_q;
    assign ioctl_download = dl_q;
    assign ioctl_upload   = ul_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = {{(c_IOCTL_AW-BUF_AW){1'b0}}, addr_q};
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;

endmodule

`default_nettype wire

// File: tb/tb_ioctl_streamer.sv
// ============================================================================
//  Module      : tb_ioctl_streamer
//  Description : Scoreboard bench for ioctl_streamer with buffer and consumer models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ioctl_streamer;
    import ioctl_pkg::*;

    localparam int BUF_AW  = 8;
    localparam int WR_GAP  = 3;
    localparam int UL_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_start = 1'b0;
    logic              cmd_upload = 1'b0;
    logic [7:0]        cmd_index = '0;
    logic [BUF_AW:0]   cmd_length = '0;
    logic              busy, done, buf_we;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0]        buf_rdata, buf_wdata;
    logic              ioctl_download, ioctl_upload, ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout, ioctl_din, ioctl_index;

    always #5 clk = ~clk;

    ioctl_streamer #(.BUF_AW(BUF_AW), .WR_GAP(WR_GAP), .UL_HOLD(UL_HOLD)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_upload(cmd_upload),
        .cmd_index(cmd_index), .cmd_length(cmd_length),
        .busy(busy), .done(done),
        .buf_addr(buf_addr), .buf_rdata(buf_rdata),
        .buf_wdata(buf_wdata), .buf_we(buf_we),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_index(ioctl_index)
    );

    // Local buffer (1-cycle RAM) and consumer memory with bench load ports.
    logic [7:0] bmem [0:255];
    logic [7:0] cmem [0:255];
    logic       b_load = 1'b0, c_load = 1'b0;
    logic [7:0] b_la = '0, b_ld = '0, c_la = '0, c_ld = '0;

    always @(posedge clk) begin
        buf_rdata <= bmem[buf_addr];
        if (buf_we) bmem[buf_addr] <= buf_wdata;
        if (b_load) bmem[b_la] <= b_ld;
    end

    always @(posedge clk) begin
        ioctl_din <= cmem[ioctl_addr[7:0]];
        if (ioctl_wr && ioctl_download) cmem[ioctl_addr[7:0]] <= ioctl_dout;
        if (c_load) cmem[c_la] <= c_ld;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } exp_t;

    exp_t q_wr[$];
    exp_t q_we[$];
    exp_t q_done[$];
    exp_t e_m;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_buf [0:255];
    int ref_cons[0:255];
    logic prev_dl = 1'b0, prev_ul = 1'b0;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cyc %0d",
                     name, act, act, expv, expv, cyc);
        end
    endfunction

    function automatic exp_t mk(int c, int a, int d);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT emits wr, we or done.
    always @(negedge clk) begin
        if (ioctl_wr) begin
            if (q_wr.size() == 0) chk("wr_unexpected", cyc, -1);
            else begin
                e_m = q_wr.pop_front();
                chk("wr_cycle", cyc, e_m.cyc);
                chk("wr_addr", int'(ioctl_addr), e_m.addr);
                if (e_m.data >= 0) chk("wr_dout", int'(ioctl_dout), e_m.data);
            end
        end
        if (buf_we) begin
            if (q_we.size() == 0) chk("we_unexpected", cyc, -1);
            else begin
                e_m = q_we.pop_front();
                chk("we_cycle", cyc, e_m.cyc);
                chk("we_addr", int'(buf_addr), e_m.addr);
                chk("we_data", int'(buf_wdata), e_m.data);
            end
        end
        if (done) begin
            if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
            else begin
                e_m = q_done.pop_front();
                chk("done_cycle", cyc, e_m.cyc);
                chk("done_index", int'(ioctl_index), e_m.addr);
                chk("done_strobes", int'({ioctl_download, ioctl_upload}), 0);
                chk("done_prev_mode", int'({prev_dl, prev_ul}), e_m.data);
                chk("done_busy", int'(busy), 0);
            end
        end
        prev_dl = ioctl_download;
        prev_ul = ioctl_upload;
    end

    task automatic load_buf(int a, int d);
        b_load = 1'b1; b_la = 8'(a); b_ld = 8'(d);
        ref_buf[a] = d;
        @(negedge clk);
        b_load = 1'b0;
    endtask

    task automatic load_cons(int a, int d);
        c_load = 1'b1; c_la = 8'(a); c_ld = 8'(d);
        ref_cons[a] = d;
        @(negedge clk);
        c_load = 1'b0;
    endtask

    task automatic start(bit up, int idx, int len, output int a);
        cmd_start  = 1'b1;
        cmd_upload = up;
        cmd_index  = 8'(idx);
        cmd_length = (BUF_AW+1)'(len);
        a = cyc + 1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic expect_dl(int a, int n, int idx);
        for (int k = 0; k < n; k++)
            q_wr.push_back(mk(a + 2 + k*(2+WR_GAP), k, ref_buf[k]));
        if (n == 0) q_done.push_back(mk(a + 1, idx, 2));
        else q_done.push_back(mk(a + 2 + (n-1)*(2+WR_GAP) + WR_GAP + 1, idx, 2));
    endtask

    task automatic expect_ul(int a, int n, int idx);
        for (int k = 0; k < n; k++) begin
            q_wr.push_back(mk(a + (k+1)*(UL_HOLD+1), (k < n-1) ? k+1 : k, -1));
            q_we.push_back(mk(a + (k+1)*(UL_HOLD+1), k, ref_cons[k]));
        end
        q_done.push_back(mk(a + n*(UL_HOLD+1) + 1, idx, 1));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && q_done.size() > 0; k++) @(negedge clk);
        if (q_done.size() > 0) begin
            chk("done_timeout", q_done.size(), 0);
            q_done.delete(); q_wr.delete(); q_we.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({ioctl_download, ioctl_upload, ioctl_wr, done, buf_we}), 0);
        chk("rst_addr", int'(ioctl_addr), 0);
        chk("rst_index", int'(ioctl_index), 0);
        chk("rst_dout", int'(ioctl_dout), 0);
        chk("rst_buf_addr", int'(buf_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        // Three-byte config download.
        load_buf(0, 8'hAA); load_buf(1, 8'hBB); load_buf(2, 8'hCC);
        start(1'b0, 3, 3, a);
        chk("busy_after_start", int'(busy), 1);
        expect_dl(a, 3, 3);
        wait_idle();
        chk("index_held", int'(ioctl_index), 3);
        chk("addr_held", int'(ioctl_addr), 2);

        // Four-byte upload from the consumer.
        load_cons(0, 8'h10); load_cons(1, 8'h20); load_cons(2, 8'h30); load_cons(3, 8'h40);
        start(1'b1, 4, 4, a);
        expect_ul(a, 4, 4);
        wait_idle();
        for (int k = 0; k < 4; k++) chk("ul_buf", int'(bmem[k]), ref_cons[k]);

        // Zero-length download.
        start(1'b0, 5, 0, a);
        expect_dl(a, 0, 5);
        wait_idle();
        chk("len0_index", int'(ioctl_index), 5);

        // A start request during a download is dropped.
        for (int k = 0; k < 4; k++) load_buf(k, 8'h51 + k*8'h11);
        start(1'b0, 3, 4, a);
        expect_dl(a, 4, 3);
        repeat (4) @(negedge clk);
        cmd_start = 1'b1; cmd_upload = 1'b1; cmd_index = 8'd9; cmd_length = 9'd1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_idle();
        chk("mid_start_index", int'(ioctl_index), 3);
        chk("mid_start_upload", int'(ioctl_upload), 0);

        // Reset during the second byte of a 16-byte download.
        for (int k = 0; k < 16; k++) load_buf(k, 8'hE0 + k);
        start(1'b0, 3, 16, a);
        q_wr.push_back(mk(a + 2, 0, ref_buf[0]));
        while (cyc < a + 6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", int'({ioctl_download, ioctl_upload, ioctl_wr, done, busy}), 0);
        chk("rst_mid_addr", int'(ioctl_addr), 0);
        chk("rst_mid_index", int'(ioctl_index), 0);
        chk("rst_mid_dout", int'(ioctl_dout), 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rst_mid_pending_wr", q_wr.size(), 0);

        // Config then dump download, then upload the dump back into a cleared buffer.
        for (int k = 0; k < 6; k++) load_buf(k, 8'h3C ^ (k*8'h25));
        start(1'b0, int'(HS_CONFIGINDEX), 6, a);
        expect_dl(a, 6, int'(HS_CONFIGINDEX));
        wait_idle();
        start(1'b0, int'(HS_DUMPINDEX), 6, a);
        expect_dl(a, 6, int'(HS_DUMPINDEX));
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            chk("rt_consumer", int'(cmem[k]), ref_buf[k]);
            ref_cons[k] = ref_buf[k];
        end
        for (int k = 0; k < 6; k++) load_buf(k, 0);
        start(1'b1, int'(HS_DUMPINDEX), 6, a);
        expect_ul(a, 6, int'(HS_DUMPINDEX));
        wait_idle();
        for (int k = 0; k < 6; k++) chk("rt_buf", int'(bmem[k]), ref_cons[k]);

        chk("left_wr", q_wr.size(), 0);
        chk("left_we", q_we.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
